// File: rtl/ff_bank_pkg.sv
// Shared mode encoding and SR conflict-resolution constants for the ff_bank slice.
package ff_bank_pkg;

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_e;

  localparam int unsigned SR_HOLD     = 0;
  localparam int unsigned SR_SET_WINS = 1;
  localparam int unsigned SR_RST_WINS = 2;

  // Resolved next value of one channel when S and R are both asserted.
  function automatic logic sr_conflict(input logic q, input int unsigned policy);
    case (policy)
      SR_SET_WINS: return 1'b1;
      SR_RST_WINS: return 1'b0;
      default:     return q;
    endcase
  endfunction

endpackage

// File: rtl/ff_cell.sv
// Combinational next-state and illegal-input detection for one flip-flop channel.
module ff_cell
  import ff_bank_pkg::*;
#(
  parameter int unsigned SR_POLICY = SR_HOLD
) (
  input  mode_e mode_i,
  input  logic  q_i,
  input  logic  a_i,
  input  logic  b_i,
  output logic  d_o,
  output logic  illegal_o
);

  always_comb begin
    d_o       = q_i;
    illegal_o = 1'b0;
    case (mode_i)
      MODE_SR: begin
        unique case ({a_i, b_i})
          2'b00: d_o = q_i;
          2'b01: d_o = 1'b0;
          2'b10: d_o = 1'b1;
          2'b11: begin
            d_o       = sr_conflict(q_i, SR_POLICY);
            illegal_o = 1'b1;
          end
          default: d_o = q_i;
        endcase
      end
      MODE_JK: begin
        unique case ({a_i, b_i})
          2'b00: d_o = q_i;
          2'b01: d_o = 1'b0;
          2'b10: d_o = 1'b1;
          2'b11: d_o = ~q_i;
          default: d_o = q_i;
        endcase
      end
      MODE_D:  d_o = a_i;
      MODE_T:  d_o = q_i ^ a_i;
      default: d_o = q_i;
    endcase
  end

endmodule

// File: rtl/ff_bank.sv
// Bank of WIDTH configurable SR/JK/D/T flip-flops with change pulses and illegal-SR tracking.
module ff_bank
  import ff_bank_pkg::*;
#(
  parameter int unsigned          WIDTH     = 8,
  parameter logic [WIDTH-1:0]     RESET_VAL = '1,
  parameter int unsigned          SR_POLICY = SR_HOLD,
  parameter int unsigned          CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] chg,
  output logic [WIDTH-1:0] err,
  output logic [CNT_W-1:0] err_cnt
);

  mode_e            mode_s;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] ill;
  logic [WIDTH-1:0] ill_v;
  logic             ill_any;

  logic [WIDTH-1:0] q_q,   q_d;
  logic [WIDTH-1:0] chg_q, chg_d;
  logic [WIDTH-1:0] err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign mode_s = mode_e'(mode);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell #(
      .SR_POLICY (SR_POLICY)
    ) u_cell (
      .mode_i    (mode_s),
      .q_i       (q_q[i]),
      .a_i       (a[i]),
      .b_i       (b[i]),
      .d_o       (nxt[i]),
      .illegal_o (ill[i])
    );
  end

  // A fresh illegal event on the same edge as clr_err survives the clear.
  always_comb begin
    q_d     = en ? nxt : q_q;
    chg_d   = q_d ^ q_q;
    ill_v   = en ? ill : '0;
    ill_any = |ill_v;
    err_d   = (clr_err ? '0 : err_q) | ill_v;
    cnt_d   = cnt_q;
    if (clr_err) begin
      cnt_d = ill_any ? CNT_W'(1) : '0;
    end else if (ill_any && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= RESET_VAL;
      chg_q <= '0;
      err_q <= '0;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      chg_q <= chg_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign q       = q_q;
  assign qb      = ~q_q;
  assign chg     = chg_q;
  assign err     = err_q;
  assign err_cnt = cnt_q;

endmodule
